// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous memory between fetch (IF) and load/store (D).
// Define ARB_RR_EN for round-robin contention; default is D priority with an IF starvation guard.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [MEM_LAT-1:0] tag_vld_q, tag_vld_d;
    // Owner bit per tag stage: 1 = D, 0 = IF.
    logic [MEM_LAT-1:0] tag_own_q, tag_own_d;
    logic               if_win, d_win;
    logic               tag_in_vld, tag_in_own;

`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;

    always_comb begin
        if_win       = if_req & (~d_req | last_owner_q);
        d_win        = d_req & ~if_win;
        last_owner_d = (if_req & d_req) ? d_win : last_owner_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    always_comb begin
        if_win = if_req & (~d_req | (wait_cnt_q == MaxWaitC));
        d_win  = d_req & ~if_win;
    end
`endif

    // Grants are masked while reset is held so every output reads 0 in reset.
    always_comb begin
        if_gnt    = if_win & rst_n;
        d_gnt     = d_win & rst_n;
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt ? d_we : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end else begin
            mem_addr = '0;
        end
    end

    always_comb begin
        wait_cnt_d = 4'd0;
        if (if_req && !if_gnt) begin
            wait_cnt_d = (wait_cnt_q == MaxWaitC) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    assign tag_in_vld = if_gnt | (d_gnt & ~(|d_we));
    assign tag_in_own = d_gnt;

    if (MEM_LAT > 1) begin : g_shift
        assign tag_vld_d = {tag_vld_q[MEM_LAT-2:0], tag_in_vld};
        assign tag_own_d = {tag_own_q[MEM_LAT-2:0], tag_in_own};
    end else begin : g_single
        assign tag_vld_d = tag_in_vld;
        assign tag_own_d = tag_in_own;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 4'd0;
            tag_vld_q  <= '0;
            tag_own_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_own_q  <= tag_own_d;
        end
    end

    assign if_rvalid = tag_vld_q[MEM_LAT-1] & ~tag_own_q[MEM_LAT-1];
    assign d_rvalid  = tag_vld_q[MEM_LAT-1] & tag_own_q[MEM_LAT-1];
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level model (response queue keyed by due cycle, word memory map).
module tb_imem_dmem_arbiter;

    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MEM_LAT  = 1;
    localparam int unsigned MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              d_req, d_gnt, d_rvalid;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata, d_rdata;
    logic              mem_en, busy;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT),
        .MAX_WAIT(MAX_WAIT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;

    typedef struct {
        longint      due;
        bit          own_d;
        logic [31:0] data;
    } rsp_t;
    rsp_t rsp_q[$];

    logic [31:0] ref_mem [int];
    logic [31:0] env_mem [int];
    logic [31:0] rd_pipe [MEM_LAT];

    int          waited      = 0;
    bit          last_d      = 1'b0;
    bit          last_if_gnt = 1'b0;
    bit          last_d_gnt  = 1'b0;
    logic [31:0] last_d_rdata;
    logic        cap_en;
    logic [3:0]  cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0] cap_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return 32'(a) * 32'h9E37_79B1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] env_read(input int a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    // Memory behaviour applied at the clock edge from the port values seen at the prior negedge.
    task automatic env_update();
        for (int i = int'(MEM_LAT) - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = cap_en ? env_read(int'(cap_addr)) : 32'h0;
        if (cap_en && cap_we != 4'h0)
            env_mem[int'(cap_addr)] = merge(env_read(int'(cap_addr)), cap_wdata, cap_we);
        mem_rdata = rd_pipe[MEM_LAT-1];
    endtask

    task automatic monitor();
        bit          exp_if, exp_d, exp_irv, exp_drv;
        logic [31:0] exp_rd;
        cap_en = mem_en; cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
        if (d_rvalid) last_d_rdata = d_rdata;
        if (!rst_n) begin
            check("rst_flags", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, busy, mem_we}), 0);
            check("rst_addr", 64'(mem_addr), 0);
            check("rst_wdata", 64'(mem_wdata), 0);
            rsp_q.delete();
            waited = 0; last_d = 1'b0; last_if_gnt = 1'b0; last_d_gnt = 1'b0;
            return;
        end
        check("busy", 64'(busy), 64'(rsp_q.size() != 0));
        exp_irv = 1'b0; exp_drv = 1'b0; exp_rd = 32'h0;
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            exp_irv = !rsp_q[0].own_d;
            exp_drv = rsp_q[0].own_d;
            exp_rd  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        check("if_rvalid", 64'(if_rvalid), 64'(exp_irv));
        check("d_rvalid", 64'(d_rvalid), 64'(exp_drv));
        if (exp_irv) check("if_rdata", 64'(if_rdata), 64'(exp_rd));
        if (exp_drv) check("d_rdata", 64'(d_rdata), 64'(exp_rd));

        if (if_req && d_req) begin
`ifdef ARB_RR_EN
            exp_if = last_d;
            last_d = !exp_if;
`else
            exp_if = (waited >= int'(MAX_WAIT));
`endif
            exp_d = !exp_if;
        end else begin
            exp_if = if_req;
            exp_d  = d_req;
        end
        check("if_gnt", 64'(if_gnt), 64'(exp_if));
        check("d_gnt", 64'(d_gnt), 64'(exp_d));
        check("mem_en", 64'(mem_en), 64'(exp_if | exp_d));
        check("mem_we", 64'(mem_we), exp_d ? 64'(d_we) : 64'h0);
        check("mem_addr", 64'(mem_addr), exp_if ? 64'(if_addr) : (exp_d ? 64'(d_addr) : 64'h0));
        check("mem_wdata", 64'(mem_wdata), exp_d ? 64'(d_wdata) : 64'h0);

        if (exp_if) rsp_q.push_back('{cyc + MEM_LAT, 1'b0, ref_read(int'(if_addr))});
        if (exp_d) begin
            if (d_we == 4'h0) rsp_q.push_back('{cyc + MEM_LAT, 1'b1, ref_read(int'(d_addr))});
            else ref_mem[int'(d_addr)] = merge(ref_read(int'(d_addr)), d_wdata, d_we);
        end
        if (if_req && !exp_if) waited = (waited >= int'(MAX_WAIT)) ? int'(MAX_WAIT) : waited + 1;
        else waited = 0;
        last_if_gnt = if_gnt;
        last_d_gnt  = d_gnt;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        env_update();
        cyc++;
        #1;
    endtask

    initial begin
        bit exp_if;
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 14'h1;
        d_req = 1'b1; d_we = 4'h0; d_addr = 14'h2; d_wdata = 32'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_first_d", 64'(last_d_gnt), 1);

        // Preload 0x10..0x13, then fetch them back-to-back.
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_req = 1'b1; d_we = 4'hF; d_addr = 14'(16 + i); d_wdata = 32'hC0DE_0000 + 32'(i);
            tick();
            check("preload_gnt", 64'(last_d_gnt), 1);
        end
        d_req = 1'b0; d_we = 4'h0;
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = 14'(16 + i);
            tick();
            check("if_stream_gnt", 64'(last_if_gnt), 1);
        end
        if_req = 1'b0;
        repeat (MEM_LAT + 1) tick();

        // Sustained contention from a clean state.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 14'h40; d_req = 1'b1; d_we = 4'h0; d_addr = 14'h41;
        for (int i = 0; i < 12; i++) begin
            tick();
`ifdef ARB_RR_EN
            exp_if = (i % 2 == 1);
`else
            exp_if = (i % (int'(MAX_WAIT) + 1) == int'(MAX_WAIT));
`endif
            check("cont_pattern", 64'({last_if_gnt, last_d_gnt}), 64'({exp_if, !exp_if}));
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (MEM_LAT + 1) tick();

        // Partial write merges into the existing word.
        d_req = 1'b1; d_addr = 14'h20; d_we = 4'hF; d_wdata = 32'hAABB_CCDD;
        tick();
        d_we = 4'b0011; d_wdata = 32'h1122_3344;
        tick();
        check("merge_we", 64'(cap_we), 64'h3);
        d_we = 4'h0;
        last_d_rdata = 32'h0;
        tick();
        d_req = 1'b0;
        repeat (MEM_LAT + 1) tick();
        check("merge_rdata", 64'(last_d_rdata), 64'hAABB_3344);

        // Reset while reads are in flight.
        if_req = 1'b1; if_addr = 14'h30; d_req = 1'b1; d_we = 4'h0; d_addr = 14'h31;
        tick();
        tick();
        if_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_busy", 64'(busy), 0);
        repeat (MEM_LAT + 3) tick();

        // Random traffic; requests stay stable until granted.
        for (int n = 0; n < 3000; n++) begin
            if (!if_req || last_if_gnt) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 14'($urandom_range(0, 255));
            end
            if (!d_req || last_d_gnt) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_addr  = 14'($urandom_range(0, 255));
                d_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                d_wdata = $urandom;
            end
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (MEM_LAT + 2) tick();
        check("drain_busy", 64'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
